// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// The state encoding is imported by both the design and its bench.
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Signed overflow of a - b from the operand sign bits and the result sign bit.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: d = a - b - bin with borrow-out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, LSB first, one full-subtractor cell reused over N cycles.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int CNT_W = $clog2(N);

    state_t         state, state_nxt;
    logic [N-1:0]   a_sh, b_sh;
    logic [N-2:0]   res;
    logic [N-1:0]   res_nxt;
    logic [CNT_W-1:0] cnt;
    logic           brw;
    logic           a_msb, b_msb;
    logic           d_bit, bo_bit;
    logic           last;

    full_sub u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .diff (d_bit),
        .bout (bo_bit)
    );

    // Incoming bit lands on top; on the final bit this is the complete result.
    assign res_nxt = {d_bit, res};
    assign last    = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        res   <= '0;
                        a_msb <= a[N-1];
                        b_msb <= b[N-1];
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[N-1:1]};
                    b_sh <= {1'b0, b_sh[N-1:1]};
                    res  <= res_nxt[N-1:1];
                    brw  <= bo_bit;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        diff <= res_nxt;
                        bout <= bo_bit;
                        ovf  <= ovf_calc(a_msb, b_msb, d_bit);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (N=8): results, latency, handshake and reset abort.
module tb_serial_sub;
    import serial_sub_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, bin;
    logic [7:0] a, b;
    logic       busy, done, bout, ovf;
    logic [7:0] diff;

    int checks = 0;
    int errors = 0;

    serial_sub #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one accepting edge.
    task automatic launch(input logic [7:0] ai, input logic [7:0] bi, input logic ci);
        a = ai; b = bi; bin = ci; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycles counted from the edge preceding the call until done is seen.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 40);
        if (!done) check("timeout", 0, 1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                          input logic ci, input logic [7:0] ed, input logic eb, input logic eo);
        int cyc;
        launch(ai, bi, ci);
        check({tag, "_busy"}, busy, 1);
        wait_done(cyc);
        check({tag, "_lat"}, cyc, 8);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovf"}, ovf, eo);
        tick();
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_hold"}, diff, ed);
    endtask

    initial begin
        int cyc;
        int seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", dut.state, IDLE);
        rst = 1'b0;
        tick();

        run_op("t1", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);
        run_op("t2", 8'd5, 8'd10, 1'b0, 8'hFB, 1'b1, 1'b0);
        run_op("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op("t4a", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("t4b", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Start while busy is ignored; start in the done cycle is taken.
        launch(8'd100, 8'd37, 1'b0);
        check("t5_state", dut.state, RUN);
        tick(); tick();
        a = 8'hAA; b = 8'h55; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        check("t5_diff", diff, 8'd63);
        check("t5_bout", bout, 0);
        a = 8'h10; b = 8'h20; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_busy2", busy, 1);
        wait_done(cyc);
        check("t5_gap", cyc + 1, 9);
        check("t5_diff2", diff, 8'hEF);
        check("t5_bout2", bout, 1);
        check("t5_ovf2", ovf, 0);
        tick();

        // Reset mid-run aborts with no done pulse.
        launch(8'd100, 8'd37, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_diff", diff, 0);
        check("t6_state", dut.state, IDLE);
        seen = 0;
        repeat (12) begin
            tick();
            if (done) seen++;
        end
        check("t6_no_done", seen, 0);
        run_op("t6_fresh", 8'hC8, 8'h32, 1'b1, 8'h95, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
